udma_ethernet_rx_desc_ctrl: RTL and testbench
=============================================

# udma_ethernet_rx_desc_ctrl

- Four-slot RX descriptor ring controller sitting between the Ethernet MAC RX byte stream and the uDMA RX channel.
- For each frame it picks the next free slot, arms the channel with that slot's start address, and forwards the bytes.
- On a good frame end it publishes the new ring pointer and frame size; the register interface turns that into a descriptor entry (bit31 = full, size in low bits).
- It drops frames when the ring is full, on MAC error, or on oversize.

## Interface
Parameters:
- L2_AWIDTH_NOAL, 12, L2 address width.
- TRANS_SIZE, 16, size/byte-count width.
- MAX_FRAME, 1522, channel size programmed per slot; frames longer than this are truncated and dropped.

Ports:
- clk_i  in  1  clock.
- rstn_i  in  1  reset, asynchronous, active-low.
- en_rx_i  in  1  RX path enable from setup register.
- cfg_rx_startaddr0_i..cfg_rx_startaddr3_i  in  L2_AWIDTH_NOAL each  slot start addresses.
- slot_full_i  in  4  bit31 of each descriptor; 1 = owned by software, not usable.
- rx_valid_i, rx_data_i[7:0], rx_last_i, rx_err_i  in  1/8/1/1  MAC byte stream; rx_err_i is qualified with rx_last_i.
- rx_ready_o  out  1  byte accepted when rx_valid_i & rx_ready_o.
- udma_valid_o, udma_data_o  out  1/8  bytes toward the uDMA channel.
- udma_ready_i  in  1  channel backpressure.
- ch_startaddr_o  out  L2_AWIDTH_NOAL  channel start address.
- ch_size_o  out  TRANS_SIZE  channel size, constant MAX_FRAME.
- ch_en_o  out  1  one-cycle channel start pulse.
- ch_clr_o  out  1  one-cycle channel abort pulse.
- rx_pointer_o  out  2  last committed slot; feeds cfg_rx_pointer_i.
- rx_size_o  out  TRANS_SIZE  committed frame length; feeds cfg_rx_size_i.
- frame_done_o  out  1  one-cycle commit pulse (RX irq source).
- drop_cnt_o  out  16  dropped-frame counter.

## Operation
- The next slot is nxt = rx_pointer_o + 1, mod 4. After reset rx_pointer_o = 2'b11, so the first slot is 0.
- FSM states: IDLE, ARM, RECV, DROP, COMMIT, ABORT.
- IDLE, with en_rx_i=1 and slot_full_i[nxt]=0: go to ARM.
- IDLE, with rx_valid_i=1 and (slot_full_i[nxt]=1 or en_rx_i=0): go to DROP and increment drop_cnt_o.
- ARM:
  - ch_startaddr_o <= cfg_rx_startaddr[nxt]; pulse ch_en_o.
  - Clear byte_cnt; go to RECV.
- RECV:
  - Bytes pass through: rx_ready_o = udma_ready_i, udma_valid_o = rx_valid_i, data unregistered.
  - byte_cnt increments per accepted byte.
  - Accepted byte with rx_last_i and !rx_err_i: go to COMMIT.
  - Accepted byte with rx_last_i and rx_err_i: go to ABORT.
  - byte_cnt reaches MAX_FRAME with no last: go to DROP, with a pending abort.
- COMMIT, for one cycle:
  - rx_size_o <= byte_cnt and rx_pointer_o <= nxt, on the same edge.
  - Pulse frame_done_o; go to IDLE.
- ABORT: pulse ch_clr_o and increment drop_cnt_o. The slot is not committed and is re-armed for the next frame. Go to IDLE.
- DROP:
  - rx_ready_o = 1, udma_valid_o = 0; bytes are discarded until an accepted rx_last_i.
  - Then go to ABORT if the drop came from oversize, otherwise to IDLE.
- drop_cnt_o saturates at 16'hFFFF.
- A slot_full_i change during RECV has no effect; the ring is only sampled in IDLE.
- en_rx_i falling during RECV: the current frame completes normally.

## Timing
- Reset values:
  - rx_pointer_o = 2'b11.
  - rx_size_o, ch_startaddr_o, drop_cnt_o = 0.
  - All pulses and valid/ready = 0.
  - State = IDLE.
- rx_ready_o is 0 in IDLE, ARM, COMMIT and ABORT. The MAC is held for at least 2 cycles between frames.
- Frame start to ch_en_o: 2 cycles (IDLE→ARM→RECV), 0 extra if en/ring are already OK.
- Last byte accepted to rx_pointer_o/rx_size_o update: 1 cycle. The two outputs are stable together; the register interface detects the pointer change and latches size on the following edge.
- Four consecutive commits with no software release: ring full, and the 5th frame is dropped.
- A reset assertion mid-frame returns everything to reset values immediately; the partially written slot is never committed.

## Configuration
- ETH_RX_DESC_DROPCNT_EN
  - Defined: drop_cnt_o counts as described.
  - Undefined: the counter logic is removed and drop_cnt_o is tied to 16'h0.
  - FSM, ch_clr_o and drop behaviour are identical in both cases.

## Test plan
- Reset, then a 64-byte good frame with slot_full_i=0 → ch_startaddr_o=startaddr0, ch_en_o pulse, 64 bytes on udma, then rx_pointer_o=0, rx_size_o=64, one frame_done_o.
- 5 good frames of 100 B, slot_full_i set by the bench per commit → slots 0,1,2,3 committed, 5th dropped, drop_cnt_o=1, rx_pointer_o stays 3.
- Frame with rx_err_i on last → ch_clr_o pulse, no pointer change, drop_cnt_o+1; the next good frame lands in the same slot.
- 1600-byte frame, MAX_FRAME=1522 → 1522 bytes forwarded, remaining 78 discarded with rx_ready_o=1, then ch_clr_o, no commit.
- udma_ready_i toggling 50% during a 200 B frame → rx_ready_o mirrors it, byte_cnt=200, rx_size_o=200.
- Reset asserted at byte 30 of a frame → rx_pointer_o=3, all outputs at reset values; the next frame arms slot 0.

Source files
------------

// File: rtl/udma_ethernet_rx_desc_ctrl.sv
// ---------------------------------------------------------------------------
// udma_ethernet_rx_desc_ctrl
//
// Four-slot RX descriptor ring controller between the Ethernet MAC RX byte
// stream and the uDMA RX channel. For every frame it picks the next free ring
// slot, arms the channel with that slot's start address and forwards the
// bytes. A good frame is committed by publishing the new ring pointer
// together with the frame size. Frames are dropped when the ring is full,
// when RX is disabled, on a MAC error, or when they exceed MAX_FRAME bytes.
//
// Optional feature macro: ETH_RX_DESC_DROPCNT_EN
//   defined   -> drop_cnt_o counts dropped frames (saturating at 16'hFFFF)
//   undefined -> no counter logic, drop_cnt_o is tied to 16'h0
//
// Ports:
//   clk_i, rstn_i               clock, asynchronous active-low reset
//   en_rx_i                     RX path enable
//   cfg_rx_startaddr0..3_i      start address of each ring slot
//   slot_full_i[3:0]            1 = slot owned by software, not usable
//   rx_valid_i/rx_data_i/
//   rx_last_i/rx_err_i          MAC byte stream (err qualified by last)
//   rx_ready_o                  byte accepted on rx_valid_i & rx_ready_o
//   udma_valid_o/udma_data_o    bytes toward the uDMA channel
//   udma_ready_i                channel backpressure
//   ch_startaddr_o/ch_size_o    channel start address / size (MAX_FRAME)
//   ch_en_o, ch_clr_o           one-cycle channel start / abort pulses
//   rx_pointer_o, rx_size_o     last committed slot and its frame length
//   frame_done_o                one-cycle commit pulse
//   drop_cnt_o                  dropped-frame counter
// ---------------------------------------------------------------------------
module udma_ethernet_rx_desc_ctrl #(
    parameter int L2_AWIDTH_NOAL = 12,
    parameter int TRANS_SIZE     = 16,
    parameter int MAX_FRAME      = 1522
) (
    input  logic                      clk_i,
    input  logic                      rstn_i,
    input  logic                      en_rx_i,
    input  logic [L2_AWIDTH_NOAL-1:0] cfg_rx_startaddr0_i,
    input  logic [L2_AWIDTH_NOAL-1:0] cfg_rx_startaddr1_i,
    input  logic [L2_AWIDTH_NOAL-1:0] cfg_rx_startaddr2_i,
    input  logic [L2_AWIDTH_NOAL-1:0] cfg_rx_startaddr3_i,
    input  logic [3:0]                slot_full_i,
    input  logic                      rx_valid_i,
    input  logic [7:0]                rx_data_i,
    input  logic                      rx_last_i,
    input  logic                      rx_err_i,
    output logic                      rx_ready_o,
    output logic                      udma_valid_o,
    output logic [7:0]                udma_data_o,
    input  logic                      udma_ready_i,
    output logic [L2_AWIDTH_NOAL-1:0] ch_startaddr_o,
    output logic [TRANS_SIZE-1:0]     ch_size_o,
    output logic                      ch_en_o,
    output logic                      ch_clr_o,
    output logic [1:0]                rx_pointer_o,
    output logic [TRANS_SIZE-1:0]     rx_size_o,
    output logic                      frame_done_o,
    output logic [15:0]               drop_cnt_o
);

    localparam logic [TRANS_SIZE-1:0] MAX_CNT = TRANS_SIZE'(MAX_FRAME);

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        RECV,
        DROP,
        COMMIT,
        ABORT
    } state_t;

    state_t                    state;
    logic [TRANS_SIZE-1:0]     byte_cnt;
    logic [TRANS_SIZE-1:0]     byte_cnt_inc;
    logic                      pend_abort;
    logic [1:0]                nxt;
    logic                      arm_ok;
    logic                      accept;
    logic [L2_AWIDTH_NOAL-1:0] start_addr [4];

    assign start_addr[0] = cfg_rx_startaddr0_i;
    assign start_addr[1] = cfg_rx_startaddr1_i;
    assign start_addr[2] = cfg_rx_startaddr2_i;
    assign start_addr[3] = cfg_rx_startaddr3_i;

    // The ring advances one slot per committed frame; the 2-bit add wraps mod 4,
    // so the reset pointer of 3 makes slot 0 the first one used.
    assign nxt          = rx_pointer_o + 2'd1;
    assign arm_ok       = en_rx_i & ~slot_full_i[nxt];
    assign accept       = rx_valid_i & rx_ready_o;
    assign byte_cnt_inc = byte_cnt + TRANS_SIZE'(1);
    assign ch_size_o    = MAX_CNT;
    assign udma_data_o  = rx_data_i;

    // Byte handshake is purely a function of the current state: in RECV the
    // MAC sees the channel's backpressure directly, in DROP every byte is
    // swallowed, and everywhere else the MAC is held off.
    always_comb begin
        rx_ready_o   = 1'b0;
        udma_valid_o = 1'b0;
        unique case (state)
            RECV: begin
                rx_ready_o   = udma_ready_i;
                udma_valid_o = rx_valid_i;
            end
            DROP: begin
                rx_ready_o   = 1'b1;
            end
            default: begin
                rx_ready_o   = 1'b0;
                udma_valid_o = 1'b0;
            end
        endcase
    end

    // Main frame FSM. Every registered output is updated on the edge that
    // enters the state it belongs to, so a pulse is visible exactly while the
    // FSM sits in ARM / COMMIT / ABORT, and the start address is already
    // valid while ch_en_o is high. The commit edge also counts the last byte.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state          <= IDLE;
            byte_cnt       <= '0;
            pend_abort     <= 1'b0;
            rx_pointer_o   <= 2'b11;
            rx_size_o      <= '0;
            ch_startaddr_o <= '0;
            ch_en_o        <= 1'b0;
            ch_clr_o       <= 1'b0;
            frame_done_o   <= 1'b0;
        end else begin
            ch_en_o      <= 1'b0;
            ch_clr_o     <= 1'b0;
            frame_done_o <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (arm_ok) begin
                        state          <= ARM;
                        ch_startaddr_o <= start_addr[nxt];
                        ch_en_o        <= 1'b1;
                    end else if (rx_valid_i) begin
                        state      <= DROP;
                        pend_abort <= 1'b0;
                    end
                end
                ARM: begin
                    byte_cnt <= '0;
                    state    <= RECV;
                end
                RECV: begin
                    if (accept) begin
                        byte_cnt <= byte_cnt_inc;
                        if (rx_last_i) begin
                            if (rx_err_i) begin
                                state    <= ABORT;
                                ch_clr_o <= 1'b1;
                            end else begin
                                state        <= COMMIT;
                                rx_size_o    <= byte_cnt_inc;
                                rx_pointer_o <= nxt;
                                frame_done_o <= 1'b1;
                            end
                        end else if (byte_cnt_inc == MAX_CNT) begin
                            state      <= DROP;
                            pend_abort <= 1'b1;
                        end
                    end
                end
                DROP: begin
                    if (accept && rx_last_i) begin
                        pend_abort <= 1'b0;
                        if (pend_abort) begin
                            state    <= ABORT;
                            ch_clr_o <= 1'b1;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                COMMIT: begin
                    state <= IDLE;
                end
                ABORT: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef ETH_RX_DESC_DROPCNT_EN
    logic drop_inc;

    // A frame is counted once: either when it is refused straight from IDLE,
    // or in ABORT (MAC error or oversize after the slot was armed).
    assign drop_inc = (state == ABORT) || ((state == IDLE) && !arm_ok && rx_valid_i);

    // Saturating dropped-frame counter.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            drop_cnt_o <= '0;
        end else if (drop_inc && (drop_cnt_o != 16'hFFFF)) begin
            drop_cnt_o <= drop_cnt_o + 16'd1;
        end
    end
`else
    assign drop_cnt_o = 16'h0;
`endif

endmodule

// File: tb/tb_udma_ethernet_rx_desc_ctrl.sv
// ---------------------------------------------------------------------------
// tb_udma_ethernet_rx_desc_ctrl
//
// Drives MAC frames into udma_ethernet_rx_desc_ctrl and compares the outcome
// of each frame against a frame-level reference model: a ring pointer, a set
// of software-owned slots and an "armed" flag (the controller samples the
// ring only while idle and keeps an armed slot until a frame uses it).
// Inputs change 1 time unit after the rising edge; outputs are observed on
// the falling edge.
// ---------------------------------------------------------------------------
module tb_udma_ethernet_rx_desc_ctrl;

    localparam int AW   = 12;
    localparam int TS   = 16;
    localparam int MAXF = 1522;

    logic          clk_i        = 1'b0;
    logic          rstn_i       = 1'b0;
    logic          en_rx_i      = 1'b1;
    logic [AW-1:0] addr [4];
    logic [3:0]    slot_full_i  = 4'h0;
    logic          rx_valid_i   = 1'b0;
    logic [7:0]    rx_data_i    = 8'h00;
    logic          rx_last_i    = 1'b0;
    logic          rx_err_i     = 1'b0;
    logic          udma_ready_i = 1'b1;
    logic          rx_ready_o;
    logic          udma_valid_o;
    logic [7:0]    udma_data_o;
    logic [AW-1:0] ch_startaddr_o;
    logic [TS-1:0] ch_size_o;
    logic          ch_en_o;
    logic          ch_clr_o;
    logic [1:0]    rx_pointer_o;
    logic [TS-1:0] rx_size_o;
    logic          frame_done_o;
    logic [15:0]   drop_cnt_o;

    udma_ethernet_rx_desc_ctrl #(
        .L2_AWIDTH_NOAL (AW),
        .TRANS_SIZE     (TS),
        .MAX_FRAME      (MAXF)
    ) dut (
        .clk_i               (clk_i),
        .rstn_i              (rstn_i),
        .en_rx_i             (en_rx_i),
        .cfg_rx_startaddr0_i (addr[0]),
        .cfg_rx_startaddr1_i (addr[1]),
        .cfg_rx_startaddr2_i (addr[2]),
        .cfg_rx_startaddr3_i (addr[3]),
        .slot_full_i         (slot_full_i),
        .rx_valid_i          (rx_valid_i),
        .rx_data_i           (rx_data_i),
        .rx_last_i           (rx_last_i),
        .rx_err_i            (rx_err_i),
        .rx_ready_o          (rx_ready_o),
        .udma_valid_o        (udma_valid_o),
        .udma_data_o         (udma_data_o),
        .udma_ready_i        (udma_ready_i),
        .ch_startaddr_o      (ch_startaddr_o),
        .ch_size_o           (ch_size_o),
        .ch_en_o             (ch_en_o),
        .ch_clr_o            (ch_clr_o),
        .rx_pointer_o        (rx_pointer_o),
        .rx_size_o           (rx_size_o),
        .frame_done_o        (frame_done_o),
        .drop_cnt_o          (drop_cnt_o)
    );

    // Free-running clock, period 10.
    always #5 clk_i = ~clk_i;

    // Channel backpressure: 0 = always ready, 1 = toggling every cycle,
    // anything else = random.
    int ready_mode = 0;
    always @(posedge clk_i) begin
        #1;
        case (ready_mode)
            0:       udma_ready_i = 1'b1;
            1:       udma_ready_i = ~udma_ready_i;
            default: udma_ready_i = 1'($urandom_range(0, 1));
        endcase
    end

    // Passive monitor: cumulative totals of everything the channel side sees.
    // Forwarded bytes are folded into a position-weighted sum so that lost,
    // duplicated or reordered bytes all change it.
    int unsigned   mon_bytes      = 0;
    int unsigned   mon_wsum       = 0;
    int unsigned   mon_mirror_err = 0;
    int unsigned   mon_en         = 0;
    int unsigned   mon_clr        = 0;
    int unsigned   mon_done       = 0;
    logic [AW-1:0] mon_last_addr  = '0;
    always @(negedge clk_i) begin
        if (udma_valid_o && udma_ready_i) begin
            mon_wsum  = mon_wsum + 32'(udma_data_o) * mon_bytes;
            mon_bytes = mon_bytes + 1;
        end
        if (udma_valid_o && ((rx_ready_o != udma_ready_i) || !rx_valid_i ||
                             (udma_data_o != rx_data_i)))
            mon_mirror_err = mon_mirror_err + 1;
        if (ch_en_o) begin
            mon_en        = mon_en + 1;
            mon_last_addr = ch_startaddr_o;
        end
        if (ch_clr_o)     mon_clr  = mon_clr + 1;
        if (frame_done_o) mon_done = mon_done + 1;
    end

    // Reference model state.
    int            m_ptr   = 3;
    int            m_size  = 0;
    int            m_drop  = 0;
    bit            m_armed = 1'b0;
    int unsigned   m_arms  = 0;
    int unsigned   m_done  = 0;
    int unsigned   m_clr   = 0;
    logic [AW-1:0] m_last_addr = '0;

    int unsigned vec_count  = 0;
    int unsigned miscompare = 0;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_count++;
        if (obs !== exp) begin
            miscompare++;
            $display("[TB] FAIL %s: observed %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] expDrop();
`ifdef ETH_RX_DESC_DROPCNT_EN
        return 32'(m_drop);
`else
        return 32'h0;
`endif
    endfunction

    function automatic void modelDrop();
        if (m_drop < 16'hFFFF) m_drop++;
    endfunction

    // An idle controller arms the next slot as soon as RX is enabled and that
    // slot is free; once armed it stays armed until a frame consumes it.
    function automatic void updateArm();
        int n;
        n = (m_ptr + 1) % 4;
        if (!m_armed && en_rx_i && !slot_full_i[n]) begin
            m_armed     = 1'b1;
            m_arms++;
            m_last_addr = addr[n];
        end
    endfunction

    task automatic settle(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    task automatic applyConfig(input logic new_en, input logic [3:0] new_full);
        en_rx_i     = new_en;
        slot_full_i = new_full;
        updateArm();
        settle(3);
    endtask

    // Presents one byte and waits (bounded) until it is accepted.
    task automatic sendByte(input logic [7:0] d, input logic last, input logic err, output bit ok);
        int guard;
        guard      = 0;
        rx_valid_i = 1'b1;
        rx_data_i  = d;
        rx_last_i  = last;
        rx_err_i   = err;
        @(negedge clk_i);
        while (!rx_ready_o && guard < 2000) begin
            guard++;
            @(negedge clk_i);
        end
        ok = rx_ready_o;
        @(posedge clk_i);
        #1;
        rx_valid_i = 1'b0;
        rx_last_i  = 1'b0;
        rx_err_i   = 1'b0;
    endtask

    task automatic checkState();
        checkOutput("rx_pointer", 32'(rx_pointer_o), 32'(m_ptr));
        checkOutput("rx_size", 32'(rx_size_o), 32'(m_size));
        checkOutput("drop_cnt", 32'(drop_cnt_o), expDrop());
        checkOutput("frame_done_cnt", mon_done, m_done);
        checkOutput("ch_clr_cnt", mon_clr, m_clr);
        checkOutput("ch_en_cnt", mon_en, m_arms);
        if (m_arms > 0) checkOutput("ch_startaddr", 32'(mon_last_addr), 32'(m_last_addr));
    endtask

    // Sends one whole frame, predicts its outcome and checks it. After a
    // commit the bench plays software and takes ownership of that slot.
    task automatic applyStimulus(input int len, input bit err);
        int unsigned snap_bytes, snap_mirror, exp_wsum, fwd, to_cnt;
        bit          acc, ok, oversize;
        int          n;
        logic [7:0]  d;
        acc         = m_armed;
        n           = (m_ptr + 1) % 4;
        oversize    = (len > MAXF);
        snap_bytes  = mon_bytes;
        snap_mirror = mon_mirror_err;
        exp_wsum    = mon_wsum;
        fwd         = acc ? (oversize ? 32'(MAXF) : 32'(len)) : 32'd0;
        to_cnt      = 0;
        for (int i = 0; i < len; i++) begin
            if ($urandom_range(0, 5) == 0) settle(1 + int'($urandom_range(0, 2)));
            d = 8'($urandom);
            if (32'(i) < fwd) exp_wsum = exp_wsum + 32'(d) * (snap_bytes + 32'(i));
            sendByte(d, (i == len - 1), err && (i == len - 1), ok);
            if (!ok) begin
                to_cnt++;
                break;
            end
        end
        settle(6);
        if (!acc) begin
            modelDrop();
        end else begin
            m_armed = 1'b0;
            if (oversize || err) begin
                m_clr++;
                modelDrop();
            end else begin
                m_ptr  = n;
                m_size = len;
                m_done++;
            end
        end
        updateArm();
        checkOutput("accept_timeout", to_cnt, 0);
        checkOutput("fwd_bytes", mon_bytes - snap_bytes, fwd);
        checkOutput("fwd_data", mon_wsum, exp_wsum);
        checkOutput("ready_mirror", mon_mirror_err - snap_mirror, 0);
        checkState();
        if (acc && !oversize && !err) applyConfig(en_rx_i, slot_full_i | (4'b0001 << n));
    endtask

    task automatic doReset();
        rstn_i      = 1'b0;
        rx_valid_i  = 1'b0;
        rx_last_i   = 1'b0;
        rx_err_i    = 1'b0;
        en_rx_i     = 1'b1;
        slot_full_i = 4'h0;
        @(negedge clk_i);
        checkOutput("rst_rx_pointer", 32'(rx_pointer_o), 32'd3);
        checkOutput("rst_rx_size", 32'(rx_size_o), 32'd0);
        checkOutput("rst_ch_startaddr", 32'(ch_startaddr_o), 32'd0);
        checkOutput("rst_drop_cnt", 32'(drop_cnt_o), 32'd0);
        checkOutput("rst_pulses", {29'd0, ch_en_o, ch_clr_o, frame_done_o}, 32'd0);
        checkOutput("rst_handshake", {30'd0, rx_ready_o, udma_valid_o}, 32'd0);
        @(posedge clk_i);
        #1;
        rstn_i  = 1'b1;
        m_ptr   = 3;
        m_size  = 0;
        m_drop  = 0;
        m_armed = 1'b0;
        updateArm();
        settle(3);
        checkState();
    endtask

    // Resets the controller in the middle of an armed frame.
    task automatic midFrameReset();
        int unsigned snap;
        bit          ok;
        snap = mon_bytes;
        for (int i = 0; i < 30; i++) sendByte(8'($urandom), 1'b0, 1'b0, ok);
        settle(1);
        checkOutput("partial_fwd", mon_bytes - snap, 30);
        doReset();
    endtask

    initial begin
        int len;
        for (int i = 0; i < 4; i++) addr[i] = AW'($urandom);
        doReset();
        checkOutput("ch_size", 32'(ch_size_o), 32'(MAXF));

        // single good frame into slot 0
        applyStimulus(64, 1'b0);

        // fill the ring, fifth frame dropped
        doReset();
        for (int k = 0; k < 5; k++) applyStimulus(100, 1'b0);

        // software releases everything; error frame then good frame, same slot
        applyConfig(1'b1, 4'h0);
        applyStimulus(80, 1'b1);
        applyStimulus(90, 1'b0);

        // oversize frame is truncated, discarded and aborted
        applyStimulus(1600, 1'b0);

        // channel backpressure toggling every cycle
        ready_mode = 1;
        applyStimulus(200, 1'b0);
        ready_mode = 0;

        // disabling RX while a slot is armed does not affect the pending frame
        applyConfig(1'b0, slot_full_i);
        applyStimulus(50, 1'b0);
        applyStimulus(20, 1'b0);

        // reset in the middle of a frame, next frame goes to slot 0
        applyConfig(1'b1, 4'h0);
        midFrameReset();
        applyStimulus(40, 1'b0);

        // randomized traffic with random ring releases and enable changes
        for (int k = 0; k < 40; k++) begin
            ready_mode = int'($urandom_range(0, 2));
            if ($urandom_range(0, 2) == 0)
                applyConfig(1'($urandom_range(0, 5) != 0), slot_full_i & 4'($urandom));
            len = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 3))
                                              : int'($urandom_range(4, 160));
            applyStimulus(len, 1'($urandom_range(0, 6) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompare);
        $finish;
    end

endmodule
